// File: rtl/marble_dispense_scheduler.sv
// rtl/marble_dispense_scheduler.sv - marble dispenser sequencer; `MARBLE_DISPENSE_TIMEOUT_EN adds the DISPENSE watchdog
module marble_dispense_scheduler #(
  parameter int unsigned     MW              = 10,
  parameter logic [MW-1:0]   DRY_TH          = 10'd300,
  parameter logic [MW-1:0]   MID_TH          = 10'd500,
  parameter logic [MW-1:0]   WET_TH          = 10'd700,
  parameter logic [31:0]     COOLDOWN_CYCLES = 32'd100_000_000,
  parameter logic [31:0]     TIMEOUT_CYCLES  = 32'd400_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trigger,
  input  logic [MW-1:0] moisture,
  input  logic          done_servo_marble,
  input  logic          clear_fault,
  output logic          enable_servo_marble,
  output logic [1:0]    marble_count,
  output logic          busy,
  output logic          fault,
  output logic [15:0]   total_marbles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_DISPENSE,
    S_RELEASE,
    S_COOLDOWN,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, hist_q;
  logic        done_q;
  logic        trig_rise;
  logic [1:0]  sample_count;
  logic [16:0] total_sum;
  logic [31:0] cool_cnt_q, cool_cnt_d;
  logic [1:0]  marble_count_q, marble_count_d;
  logic [15:0] total_q, total_d;
  logic        enable_q, enable_d;
  logic        busy_q, busy_d;
`ifdef MARBLE_DISPENSE_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        fault_q, fault_d;
`endif

  // Trigger synchronizer plus history flop, and a registered copy of done so
  // enable falls one edge after done is first sampled high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sync1_q <= trigger;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      done_q  <= done_servo_marble;
    end
  end

  assign trig_rise = sync2_q & ~hist_q;

  // Moisture to marble count: drier soil gets more marbles.
  always_comb begin
    sample_count = 2'd0;
    if (moisture < DRY_TH) begin
      sample_count = 2'd3;
    end else if (moisture < MID_TH) begin
      sample_count = 2'd2;
    end else if (moisture < WET_TH) begin
      sample_count = 2'd1;
    end
  end

  assign total_sum = {1'b0, total_q} + {15'd0, sample_count};

  // Next-state logic, counters and registered-output decode.
  always_comb begin
    state_d        = state_q;
    cool_cnt_d     = cool_cnt_q;
    marble_count_d = marble_count_q;
    total_d        = total_q;
`ifdef MARBLE_DISPENSE_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (trig_rise) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (sample_count == 2'd0) begin
          state_d    = S_COOLDOWN;
          cool_cnt_d = 32'd0;
        end else begin
          state_d        = S_DISPENSE;
          marble_count_d = sample_count;
          total_d        = total_sum[16] ? 16'hFFFF : total_sum[15:0];
`ifdef MARBLE_DISPENSE_TIMEOUT_EN
          to_cnt_d       = 32'd0;
`endif
        end
      end
      S_DISPENSE: begin
        if (done_q) begin
          state_d = S_RELEASE;
`ifdef MARBLE_DISPENSE_TIMEOUT_EN
        end else if (to_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
          state_d = S_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
`endif
        end
      end
      S_RELEASE: begin
        // Live done here: the servo block must drop done before we cool down.
        if (!done_servo_marble) begin
          state_d    = S_COOLDOWN;
          cool_cnt_d = 32'd0;
        end
      end
      S_COOLDOWN: begin
        if (cool_cnt_q == COOLDOWN_CYCLES - 32'd1) begin
          state_d = S_IDLE;
        end else begin
          cool_cnt_d = cool_cnt_q + 32'd1;
        end
      end
`ifdef MARBLE_DISPENSE_TIMEOUT_EN
      S_FAULT: begin
        if (clear_fault) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    enable_d = (state_d == S_DISPENSE);
    busy_d   = (state_d != S_IDLE);
`ifdef MARBLE_DISPENSE_TIMEOUT_EN
    fault_d  = (state_d == S_FAULT);
`endif
  end

  // State, counters and registered outputs; reset drops enable immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cool_cnt_q     <= 32'd0;
      marble_count_q <= 2'd0;
      total_q        <= 16'd0;
      enable_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cool_cnt_q     <= cool_cnt_d;
      marble_count_q <= marble_count_d;
      total_q        <= total_d;
      enable_q       <= enable_d;
      busy_q         <= busy_d;
    end
  end

`ifdef MARBLE_DISPENSE_TIMEOUT_EN
  // Watchdog counter and fault flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      fault_q  <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  logic unused_timeout_inputs;
  assign unused_timeout_inputs = clear_fault ^ (^TIMEOUT_CYCLES);
  assign fault = 1'b0;
`endif

  assign enable_servo_marble = enable_q;
  assign marble_count        = marble_count_q;
  assign busy                = busy_q;
  assign total_marbles       = total_q;

endmodule

// File: tb/tb_marble_dispense_scheduler.sv
// tb/tb_marble_dispense_scheduler.sv - self-checking bench for marble_dispense_scheduler
module tb_marble_dispense_scheduler;

  localparam int C_CYC = 8;
  localparam int T_CYC = 20;

  logic        clk;
  logic        reset;
  logic        trigger;
  logic [9:0]  moisture;
  logic        done_servo_marble;
  logic        clear_fault;
  logic        enable_servo_marble;
  logic [1:0]  marble_count;
  logic        busy;
  logic        fault;
  logic [15:0] total_marbles;

  int checks;
  int failures;
  int model_total;

  marble_dispense_scheduler #(
    .MW(10), .DRY_TH(10'd300), .MID_TH(10'd500), .WET_TH(10'd700),
    .COOLDOWN_CYCLES(32'd8), .TIMEOUT_CYCLES(32'd20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .trigger(trigger),
    .moisture(moisture),
    .done_servo_marble(done_servo_marble),
    .clear_fault(clear_fault),
    .enable_servo_marble(enable_servo_marble),
    .marble_count(marble_count),
    .busy(busy),
    .fault(fault),
    .total_marbles(total_marbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_count(input int m);
    if (m < 300) return 3;
    if (m < 500) return 2;
    if (m < 700) return 1;
    return 0;
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full trigger-to-idle cycle. d: cycles in DISPENSE before done rises,
  // r: extra cycles done stays high after enable falls, retrig: extra trigger
  // pulses during DISPENSE and COOLDOWN that must be dropped.
  task automatic run_cycle(input int m, input int d, input int r, input bit retrig);
    int expc;
    expc = exp_count(m);
    moisture = m[9:0];
    trigger  = 1'b1;
    tick();                                     // edge N
    tick();                                     // edge N+1
    trigger = 1'b0;
    chk("idle_before_sample", {31'd0, busy}, 0);
    tick();                                     // edge N+2
    chk("busy_in_sample", {31'd0, busy}, 1);
    chk("no_enable_in_sample", {31'd0, enable_servo_marble}, 0);
    tick();                                     // edge N+3
    if (expc == 0) begin
      chk("zero_no_enable", {31'd0, enable_servo_marble}, 0);
      chk("zero_total", {16'd0, total_marbles}, model_total);
      repeat (C_CYC - 1) tick();
      chk("zero_cool_busy", {31'd0, busy}, 1);
      tick();
      chk("zero_cool_done", {31'd0, busy}, 0);
      return;
    end
    model_total = sat16(model_total + expc);
    chk("enable_rise", {31'd0, enable_servo_marble}, 1);
    chk("count", {30'd0, marble_count}, expc);
    chk("total", {16'd0, total_marbles}, model_total);
    for (int i = 0; i < d; i++) begin
      if (retrig && i == 0) trigger = 1'b1;
      if (retrig && i == 2) trigger = 1'b0;
      tick();
    end
    trigger = 1'b0;
    chk("enable_hold", {31'd0, enable_servo_marble}, 1);
    done_servo_marble = 1'b1;
    tick();                                     // edge M
    chk("enable_at_done", {31'd0, enable_servo_marble}, 1);
    tick();                                     // edge M+1
    chk("enable_fall", {31'd0, enable_servo_marble}, 0);
    chk("count_held", {30'd0, marble_count}, expc);
    chk("busy_release", {31'd0, busy}, 1);
    repeat (r) tick();
    done_servo_marble = 1'b0;
    tick();                                     // edge D: COOLDOWN begins
    for (int i = 1; i < C_CYC; i++) begin
      if (retrig && i == 1) trigger = 1'b1;
      if (retrig && i == 3) trigger = 1'b0;
      tick();
    end
    trigger = 1'b0;
    chk("cool_busy", {31'd0, busy}, 1);
    tick();                                     // edge D+C
    chk("cool_end_busy", {31'd0, busy}, 0);
    chk("cool_end_enable", {31'd0, enable_servo_marble}, 0);
    chk("cool_end_total", {16'd0, total_marbles}, model_total);
  endtask

  initial begin
    int m, d, r;
    checks = 0;
    failures = 0;
    model_total = 0;
    reset = 1'b1;
    trigger = 1'b0;
    moisture = 10'd0;
    done_servo_marble = 1'b0;
    clear_fault = 1'b0;

    tick();
    tick();
    chk("rst_enable", {31'd0, enable_servo_marble}, 0);
    chk("rst_count", {30'd0, marble_count}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    chk("rst_total", {16'd0, total_marbles}, 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_enable", {31'd0, enable_servo_marble}, 0);

    run_cycle(100, 5, 0, 1'b0);
    chk("dry_total", {16'd0, total_marbles}, 3);
    run_cycle(300, 2, 1, 1'b0);
    run_cycle(699, 1, 2, 1'b0);
    run_cycle(700, 3, 0, 1'b0);
    run_cycle(299, 4, 0, 1'b0);
    run_cycle(499, 2, 3, 1'b0);
    run_cycle(500, 1, 0, 1'b0);
    run_cycle(1023, 1, 0, 1'b0);
    tick();

    run_cycle(100, 5, 1, 1'b1);
    repeat (6) tick();
    chk("retrig_dropped_busy", {31'd0, busy}, 0);
    chk("retrig_total", {16'd0, total_marbles}, model_total);

    for (int k = 0; k < 6; k++) begin
      m = $urandom_range(0, 1023);
      d = $urandom_range(1, 6);
      r = $urandom_range(0, 3);
      repeat ($urandom_range(1, 3)) tick();
      run_cycle(m, d, r, 1'b0);
    end

    tick();
    moisture = 10'd100;
    trigger = 1'b1;
    tick();
    tick();
    trigger = 1'b0;
    tick();
    tick();
    chk("pre_reset_enable", {31'd0, enable_servo_marble}, 1);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_enable", {31'd0, enable_servo_marble}, 0);
    chk("async_reset_busy", {31'd0, busy}, 0);
    chk("async_reset_total", {16'd0, total_marbles}, 0);
    chk("async_reset_count", {30'd0, marble_count}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_total = 0;
    tick();
    chk("post_reset_busy", {31'd0, busy}, 0);

    moisture = 10'd100;
    trigger = 1'b1;
    tick();
    tick();
    trigger = 1'b0;
    tick();
    tick();                                     // entered DISPENSE
    chk("wd_enable", {31'd0, enable_servo_marble}, 1);
    repeat (T_CYC - 1) tick();
    chk("wd_pre_enable", {31'd0, enable_servo_marble}, 1);
    chk("wd_pre_fault", {31'd0, fault}, 0);
    tick();
`ifdef MARBLE_DISPENSE_TIMEOUT_EN
    chk("wd_fault", {31'd0, fault}, 1);
    chk("wd_fault_enable", {31'd0, enable_servo_marble}, 0);
    chk("wd_fault_busy", {31'd0, busy}, 1);
    trigger = 1'b1;
    repeat (3) tick();
    trigger = 1'b0;
    repeat (3) tick();
    chk("wd_trig_ignored_fault", {31'd0, fault}, 1);
    chk("wd_trig_ignored_enable", {31'd0, enable_servo_marble}, 0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("wd_clear_fault", {31'd0, fault}, 0);
    chk("wd_clear_busy", {31'd0, busy}, 0);
`else
    chk("nowd_enable", {31'd0, enable_servo_marble}, 1);
    chk("nowd_fault", {31'd0, fault}, 0);
    clear_fault = 1'b1;
    repeat (5) tick();
    clear_fault = 1'b0;
    chk("nowd_enable_late", {31'd0, enable_servo_marble}, 1);
    chk("nowd_fault_late", {31'd0, fault}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/marble_dispense_scheduler.md
# marble_dispense_scheduler

- Top-level sequencer for the marble dispenser.
- On a trigger, samples the moisture sensor level and maps it to a marble count of 0–3.
- Drives the servo marble block through its enable/done handshake, then enforces a cooldown before the next cycle can start.
- Sits between the board trigger input and moisture-sensor interface on one side, and the servo marble block on the other; it is the only driver of that block's enable and count inputs.

## Interface
Parameters:
- MW, 10, moisture sample width
- DRY_TH, 10'd300, moisture below this → 3 marbles
- MID_TH, 10'd500, moisture below this → 2 marbles
- WET_TH, 10'd700, moisture below this → 1 marble; at or above → 0
- COOLDOWN_CYCLES, 32'd100_000_000, idle hold after each cycle (1 s at 100 MHz)
- TIMEOUT_CYCLES, 32'd400_000_000, watchdog limit in DISPENSE

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- trigger  in  1  asynchronous request (button/timer); rising edge starts a cycle
- moisture  in  MW  sensor level, quasi-static, sampled once per cycle
- done_servo_marble  in  1  completion flag from the servo marble block
- clear_fault  in  1  synchronous fault clear
- enable_servo_marble  out  1  enable to the servo marble block
- marble_count  out  2  marble count presented to the servo marble block
- busy  out  1  high in any state other than IDLE
- fault  out  1  watchdog fault flag
- total_marbles  out  16  saturating count of marbles commanded

## Operation
- The trigger passes through a 2-flop synchronizer plus a history flop. A rising edge is `sync & ~hist`.
- States and transitions:
  - IDLE → SAMPLE on a rising edge. Edges in any other state are dropped, not queued.
  - SAMPLE: one cycle.
    - Latches `moisture` and computes the count from strict less-than compares (DRY, then MID, then WET).
    - Count 0 → COOLDOWN, with no enable pulse and no total update.
    - Otherwise → DISPENSE; registers `marble_count` and adds the count to `total_marbles`.
  - DISPENSE: `enable_servo_marble`=1 while `marble_count` is held stable.
    - `done_servo_marble`=1 → RELEASE.
  - RELEASE: `enable_servo_marble`=0; waits for `done_servo_marble`=0, then → COOLDOWN.
  - COOLDOWN: counts to COOLDOWN_CYCLES-1, then → IDLE.
  - FAULT: see Configuration.
- `total_marbles` saturates at 16'hFFFF and does not wrap.
- Reset mid-operation: all state clears immediately and `enable_servo_marble` drops asynchronously, which forces the servo block back to its init state.
- Thresholds must satisfy DRY_TH < MID_TH < WET_TH. The block does not check this.

## Timing
- Reset values:
  - Outputs: `enable_servo_marble`=0, `marble_count`=0, `busy`=0, `fault`=0, `total_marbles`=0.
  - State: IDLE; all counters 0; synchronizer flops 0.
- Trigger latency: `trigger` first sampled high at edge N → edge detected after edge N+1 → SAMPLE at edge N+2 → DISPENSE (enable=1) at edge N+3.
- `marble_count` becomes valid at the same edge enable rises and is held until the next SAMPLE.
- `done_servo_marble` seen high at edge M → enable low after edge M+1.
- Minimum RELEASE duration is 1 cycle.
- COOLDOWN lasts exactly COOLDOWN_CYCLES cycles, then IDLE.
- `busy` is a registered decode of state, equal to (state != IDLE).
- All outputs are registered.

## Configuration
- Macro: `MARBLE_DISPENSE_TIMEOUT_EN`.
- Defined:
  - A 32-bit counter runs in DISPENSE.
  - Reaching TIMEOUT_CYCLES without done → FAULT: enable=0, `fault`=1, `busy`=1, triggers ignored.
  - `clear_fault`=1 in FAULT → IDLE next edge, `fault`=0.
  - The counter zeroes on entry to DISPENSE.
- Undefined:
  - No counter and no FAULT state; DISPENSE waits indefinitely.
  - `fault` is tied 0 and `clear_fault` is ignored.

## Test plan
Tests use DRY/MID/WET = 300/500/700, COOLDOWN_CYCLES=8, TIMEOUT_CYCLES=20.
- Reset then idle: `trigger`=0 → all outputs 0, `busy`=0 indefinitely.
- Dry soil: `moisture`=100, trigger pulse → enable high 3 edges after detection-sample edge, `marble_count`=3; done after 5 cycles → enable low next cycle; `busy` low 8 cycles after done falls; `total_marbles`=3.
- Boundary and wet cases:
  - `moisture`=300 → count 2.
  - `moisture`=699 → count 1.
  - `moisture`=700 → no enable pulse, straight to COOLDOWN, total unchanged.
- Trigger while busy: second rising edge during DISPENSE and COOLDOWN → ignored; exactly one dispense cycle.
- Reset mid-DISPENSE: assert reset asynchronously → enable drops without waiting for a clock edge; total=0 and state IDLE after release.
- With `MARBLE_DISPENSE_TIMEOUT_EN`: done never asserts → `fault`=1 and enable=0 after 20 cycles in DISPENSE; triggers ignored; `clear_fault` pulse → IDLE, `fault`=0. Without the macro: same stimulus → enable stays high and `fault` stays 0.
